mem_line_responder: RTL and testbench

Memory-side responder for the L2 line port: accepts one 512-bit line request at a time from the L2's `mem_req_*` outputs and returns `mem_rsp_valid` / `mem_rsp_load_data` after a programmable latency. It backs requests with an internal line array, so the core, L1s and L2 can run against a cycle-accurate memory in simulation and on FPGA without an external DRAM controller. It sits below the L2 in the core top, and its ports plug directly into that top's memory port.

---
 rtl/mem_line_responder.sv | 133 +++++++++++++
 tb/tb_mem_line_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_responder.sv
// Line-granular memory responder for the L2 memory port: one outstanding
// request, fixed programmable latency, backed by an internal line array.
module mem_line_responder #(
  parameter int unsigned LG_DEPTH = 14,
  parameter int unsigned LATENCY  = 4,
  parameter int unsigned M_WIDTH  = 32,
  parameter logic [3:0]  MEM_LW   = 4'h0,
  parameter logic [3:0]  MEM_SW   = 4'h1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_req_valid,
  input  logic [M_WIDTH-1:0] mem_req_addr,
  input  logic [511:0]       mem_req_store_data,
  input  logic [3:0]         mem_req_opcode,
  output logic               mem_rsp_valid,
  output logic [511:0]       mem_rsp_load_data,
  output logic               busy,
  output logic [31:0]        load_count,
  output logic [31:0]        store_count,
  output logic               bad_opcode
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [LG_DEPTH-1:0] idx_q, idx_d;
  logic [3:0]          op_q, op_d;
  logic [511:0]        sdata_q, sdata_d;
  logic [511:0]        rdata_q, rdata_d;
  logic [31:0]         ld_cnt_q, ld_cnt_d;
  logic [31:0]         st_cnt_q, st_cnt_d;
  logic                bad_q, bad_d;
  logic                enter_resp;
  logic                commit_st;

  logic [511:0] mem_q [2**LG_DEPTH];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_req_addr[5:0], mem_req_addr[M_WIDTH-1:LG_DEPTH+6]};

  // RESP-entry actions use the _d request fields so a LATENCY of 1 can
  // respond to the request being captured on the same edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    op_d       = op_q;
    sdata_d    = sdata_q;
    rdata_d    = rdata_q;
    ld_cnt_d   = ld_cnt_q;
    st_cnt_d   = st_cnt_q;
    bad_d      = bad_q;
    enter_resp = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_req_valid) begin
          idx_d   = mem_req_addr[LG_DEPTH+5:6];
          op_d    = mem_req_opcode;
          sdata_d = mem_req_store_data;
          cnt_d   = LAT_M1;
          if (mem_req_opcode == MEM_LW)      ld_cnt_d = ld_cnt_q + 32'd1;
          else if (mem_req_opcode == MEM_SW) st_cnt_d = st_cnt_q + 32'd1;
          else                               bad_d    = 1'b1;
          if (LATENCY > 1) begin
            state_d = WAIT;
          end else begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 8'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (enter_resp) begin
      if (op_d == MEM_LW)      rdata_d = mem_q[idx_d];
      else if (op_d != MEM_SW) rdata_d = '0;
    end
  end

  assign commit_st = enter_resp && (op_d == MEM_SW) && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      op_q     <= '0;
      sdata_q  <= '0;
      rdata_q  <= '0;
      ld_cnt_q <= '0;
      st_cnt_q <= '0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      sdata_q  <= sdata_d;
      rdata_q  <= rdata_d;
      ld_cnt_q <= ld_cnt_d;
      st_cnt_q <= st_cnt_d;
      bad_q    <= bad_d;
    end
  end

  // The array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (commit_st) mem_q[idx_d] <= sdata_d;
  end

  assign mem_rsp_valid     = (state_q == RESP);
  assign busy              = (state_q != IDLE);
  assign mem_rsp_load_data = rdata_q;
  assign load_count        = ld_cnt_q;
  assign store_count       = st_cnt_q;
  assign bad_opcode        = bad_q;

endmodule

// File: tb/tb_mem_line_responder.sv
// Randomized and directed bench for mem_line_responder against an
// edge-numbered behavioural model of request timing and line contents.
module tb_mem_line_responder;

  localparam int unsigned LAT = 4;
  localparam logic [3:0] LW  = 4'h0;
  localparam logic [3:0] SW  = 4'h1;
  localparam logic [3:0] BAD = 4'hF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         valid = 1'b0;
  logic [31:0]  addr = '0;
  logic [511:0] sdata = '0;
  logic [3:0]   op = '0;
  logic         rsp, busy, bad;
  logic [511:0] rdata;
  logic [31:0]  lc, sc;

  logic         v1 = 1'b0;
  logic [31:0]  a1 = '0;
  logic [511:0] d1 = '0;
  logic [3:0]   o1 = '0;
  logic         rsp1, busy1, bad1;
  logic [511:0] rdata1;
  logic [31:0]  lc1, sc1;

  mem_line_responder #(.LG_DEPTH(14), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .mem_req_valid(valid), .mem_req_addr(addr),
    .mem_req_store_data(sdata), .mem_req_opcode(op), .mem_rsp_valid(rsp),
    .mem_rsp_load_data(rdata), .busy(busy), .load_count(lc),
    .store_count(sc), .bad_opcode(bad));

  mem_line_responder #(.LG_DEPTH(4), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .mem_req_valid(v1), .mem_req_addr(a1),
    .mem_req_store_data(d1), .mem_req_opcode(o1), .mem_rsp_valid(rsp1),
    .mem_rsp_load_data(rdata1), .busy(busy1), .load_count(lc1),
    .store_count(sc1), .bad_opcode(bad1));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Model: a request accepted at edge A responds during the cycle after
  // edge A+LAT-1 and frees the responder at edge A+LAT.
  bit           pend = 1'b0;
  longint       edge_n = 0;
  longint       acc_edge = 0;
  logic [3:0]   p_op = '0;
  int           p_idx = 0;
  logic [511:0] p_data = '0;
  logic [511:0] m_mem [int];
  logic [511:0] e_data = '0;
  bit           e_known = 1'b1;
  logic [31:0]  e_ld = '0;
  logic [31:0]  e_st = '0;
  bit           e_bad = 1'b0;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 6) & 32'h3FFF);
  endfunction

  always @(posedge clk or posedge reset) begin
    bit was_idle;
    if (reset) begin
      pend = 1'b0; e_ld = '0; e_st = '0; e_bad = 1'b0; e_data = '0; e_known = 1'b1;
    end else begin
      was_idle = !pend;
      edge_n++;
      if (pend && edge_n == acc_edge + LAT) pend = 1'b0;
      if (was_idle && valid) begin
        pend = 1'b1; acc_edge = edge_n; p_op = op; p_idx = idx_of(addr); p_data = sdata;
        if (op == LW) e_ld++;
        else if (op == SW) e_st++;
        else e_bad = 1'b1;
      end
      if (pend && edge_n == acc_edge + LAT - 1) begin
        if (p_op == SW) m_mem[p_idx] = p_data;
        else if (p_op == LW) begin
          e_known = m_mem.exists(p_idx);
          if (e_known) e_data = m_mem[p_idx];
        end else begin
          e_data = '0; e_known = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("rsp_valid", rsp, (pend && edge_n == acc_edge + LAT - 1));
    chk("busy", busy, pend);
    chk("load_count", lc, e_ld);
    chk("store_count", sc, e_st);
    chk("bad_opcode", bad, e_bad);
    if (e_known) chk("load_data", rdata, e_data);
    chk("l1_no_wait_state", (busy1 && !rsp1), 1'b0);
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic req(input logic [3:0] o, input logic [31:0] a, input logic [511:0] d,
                     output int lat);
    wait_idle();
    valid = 1'b1; op = o; addr = a; sdata = d;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    lat = 1;
    while (!rsp && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int rises[$];
    bit prev_busy;
    int lines[8] = '{0, 1, 2, 'h41, 'h1000, 'h2AAA, 'h3FFF, 'h40};
    logic [511:0] d_a, d_b, d_c;
    d_a = {16{32'hdeadbeef}};
    d_b = {8{64'h0123456789abcdef}};
    d_c = {16{32'hcafef00d}};

    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("reset_data", rdata, '0);
    chk("reset_lc", lc, 32'd0);
    chk("reset_sc", sc, 32'd0);
    chk("reset_busy", busy, 1'b0);

    req(SW, 32'h1040, d_a, lat);
    chk("store_latency", lat, LAT);
    req(LW, 32'h1040, '0, lat);
    chk("load_latency", lat, LAT);
    chk("load_data_lit", rdata, d_a);
    chk("lc_after_pair", lc, 32'd1);
    chk("sc_after_pair", sc, 32'd1);

    req(SW, 32'h0000_0080, d_b, lat);
    req(LW, 32'h0010_00BF, '0, lat);
    chk("alias_data", rdata, d_b);

    req(BAD, 32'h1040, {16{32'hffffffff}}, lat);
    chk("bad_latency", lat, LAT);
    chk("bad_data", rdata, '0);
    chk("bad_flag", bad, 1'b1);
    chk("bad_lc", lc, 32'd2);
    chk("bad_sc", sc, 32'd2);
    req(LW, 32'h1040, '0, lat);
    chk("bad_line_kept", rdata, d_a);
    chk("bad_sticky", bad, 1'b1);

    @(negedge clk);
    o1 = SW; a1 = 32'h40; d1 = d_b; v1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0;
    chk("l1_store_rsp", rsp1, 1'b1);
    @(negedge clk);
    o1 = LW; v1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0;
    chk("l1_load_rsp", rsp1, 1'b1);
    chk("l1_load_data", rdata1, d_b);
    chk("l1_lc", lc1, 32'd1);
    chk("l1_sc", sc1, 32'd1);

    wait_idle();
    valid = 1'b1; op = LW; addr = 32'h1040;
    prev_busy = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (busy && !prev_busy) rises.push_back(i);
      prev_busy = busy;
    end
    valid = 1'b0;
    chk("busy_drop_accepts", (rises.size() >= 5), 1'b1);
    for (int i = 1; i < rises.size(); i++)
      chk("busy_drop_interval", rises[i] - rises[i-1], LAT + 1);

    wait_idle();
    valid = 1'b1; op = SW; addr = 32'h1040; sdata = d_c;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
    chk("midwait_lc", lc, 32'd0);
    chk("midwait_sc", sc, 32'd0);
    chk("midwait_bad", bad, 1'b0);
    repeat (6) begin
      @(negedge clk);
      chk("midwait_no_rsp", rsp, 1'b0);
    end
    req(LW, 32'h1040, '0, lat);
    chk("midwait_old_line", rdata, d_a);
    chk("midwait_lc_after", lc, 32'd1);

    foreach (lines[i]) req(SW, 32'(lines[i]) << 6, rnd512(), lat);
    for (int c = 0; c < 1500; c++) begin
      int r;
      @(negedge clk);
      r = int'($urandom % 16);
      valid = ($urandom % 3) != 0;
      op = (r < 8) ? LW : (r < 15) ? SW : BAD;
      addr = ($urandom & 32'hFFF0_0000) | (32'(lines[$urandom % 8]) << 6) | ($urandom & 32'h3F);
      sdata = rnd512();
    end
    valid = 1'b0;
    @(negedge clk);
    wait_idle();
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
